dual_ram_be_pipe: RTL and testbench

// Single-clock, true dual-port RAM with per-byte write strobes, a configurable

---
 rtl/dual_ram_be_pipe.sv | 128 ++++++++++++
 tb/tb_dual_ram_be_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dual_ram_be_pipe.sv
// True dual-port byte-strobed RAM with a configurable read pipeline and a
// hardware zero-fill engine that owns the array after reset or on clr.
module dual_ram_be_pipe #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0,
  localparam int STRB_W  = (DATA_W + 7) / 8
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              clr,
  output logic              busy,
  input  logic              aEn,
  input  logic [ADDR_W-1:0] aAddr,
  input  logic [DATA_W-1:0] aWrite,
  input  logic [STRB_W-1:0] aStrb,
  output logic [DATA_W-1:0] aRead,
  output logic              aRdValid,
  input  logic              bEn,
  input  logic [ADDR_W-1:0] bAddr,
  input  logic [DATA_W-1:0] bWrite,
  input  logic [STRB_W-1:0] bStrb,
  output logic [DATA_W-1:0] bRead,
  output logic              bRdValid
);

  localparam int SIZE = 1 << ADDR_W;

  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("dual_ram_be_pipe: RD_LAT must be in 1..3");
  end

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic              fill_we;
  logic              a_acc, b_acc;
  logic [DATA_W-1:0] a_rd_d, b_rd_d;

  logic [RD_LAT-1:0] a_vld_q, b_vld_q;
  logic [DATA_W-1:0] a_pipe_q [RD_LAT];
  logic [DATA_W-1:0] b_pipe_q [RD_LAT];

  assign fill_we = (state_q == S_FILL);
  assign busy    = fill_we;
  assign a_acc   = aEn & ~fill_we;
  assign b_acc   = bEn & ~fill_we;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= S_FILL;
      fill_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    case (state_q)
      S_FILL: begin
        fill_addr_d = fill_addr_q + 1'b1;
        if (fill_addr_q == {ADDR_W{1'b1}}) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (clr) begin
          state_d     = S_FILL;
          fill_addr_d = '0;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // One array per byte lane; port A is written last so it wins shared lanes.
  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
    localparam int LO = gi * 8;
    localparam int LW = (gi == STRB_W - 1) ? (DATA_W - LO) : 8;

    logic [LW-1:0] mem_q [SIZE];

    always_ff @(posedge clk) begin
      if (fill_we) begin
        mem_q[fill_addr_q] <= '0;
      end else begin
        if (b_acc && bStrb[gi]) mem_q[bAddr] <= bWrite[LO +: LW];
        if (a_acc && aStrb[gi]) mem_q[aAddr] <= aWrite[LO +: LW];
      end
    end

    // Each port only ever sees its own bytes merged, never the other port's.
    assign a_rd_d[LO +: LW] = (RDW_MODE == 0 && aStrb[gi]) ? aWrite[LO +: LW] : mem_q[aAddr];
    assign b_rd_d[LO +: LW] = (RDW_MODE == 0 && bStrb[gi]) ? bWrite[LO +: LW] : mem_q[bAddr];
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      a_vld_q <= '0;
      b_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        a_pipe_q[i] <= '0;
        b_pipe_q[i] <= '0;
      end
    end else begin
      a_vld_q[0] <= a_acc;
      b_vld_q[0] <= b_acc;
      if (a_acc) a_pipe_q[0] <= a_rd_d;
      if (b_acc) b_pipe_q[0] <= b_rd_d;
      // Stages only advance on valid data so the output holds between reads.
      for (int i = 1; i < RD_LAT; i++) begin
        a_vld_q[i] <= a_vld_q[i-1];
        b_vld_q[i] <= b_vld_q[i-1];
        if (a_vld_q[i-1]) a_pipe_q[i] <= a_pipe_q[i-1];
        if (b_vld_q[i-1]) b_pipe_q[i] <= b_pipe_q[i-1];
      end
    end
  end

  assign aRead    = a_pipe_q[RD_LAT-1];
  assign aRdValid = a_vld_q[RD_LAT-1];
  assign bRead    = b_pipe_q[RD_LAT-1];
  assign bRdValid = b_vld_q[RD_LAT-1];

endmodule

// File: tb/tb_dual_ram_be_pipe.sv
// Directed bench: one write-first RD_LAT=2 instance and one read-first RD_LAT=1
// instance share every input; each is checked against hand-computed values.
module tb_dual_ram_be_pipe;
  localparam int AW   = 6;
  localparam int DW   = 32;
  localparam int SW   = 4;
  localparam int SIZE = 64;

  logic          clk = 1'b0;
  logic          rst_n, clr;
  logic          a_en, b_en;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wr, b_wr;
  logic [SW-1:0] a_strb, b_strb;

  logic          w_busy, w_avld, w_bvld;
  logic [DW-1:0] w_ard, w_brd;
  logic          r_busy, r_avld, r_bvld;
  logic [DW-1:0] r_ard, r_brd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dual_ram_be_pipe #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .RDW_MODE(0)) u_wf (
    .clk(clk), .rstN(rst_n), .clr(clr), .busy(w_busy),
    .aEn(a_en), .aAddr(a_addr), .aWrite(a_wr), .aStrb(a_strb), .aRead(w_ard), .aRdValid(w_avld),
    .bEn(b_en), .bAddr(b_addr), .bWrite(b_wr), .bStrb(b_strb), .bRead(w_brd), .bRdValid(w_bvld)
  );

  dual_ram_be_pipe #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .RDW_MODE(1)) u_rf (
    .clk(clk), .rstN(rst_n), .clr(clr), .busy(r_busy),
    .aEn(a_en), .aAddr(a_addr), .aWrite(a_wr), .aStrb(a_strb), .aRead(r_ard), .aRdValid(r_avld),
    .bEn(b_en), .bAddr(b_addr), .bWrite(b_wr), .bStrb(b_strb), .bRead(r_brd), .bRdValid(r_bvld)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    a_en = 1'b0; a_addr = '0; a_wr = '0; a_strb = '0;
    b_en = 1'b0; b_addr = '0; b_wr = '0; b_strb = '0;
  endtask

  // One access cycle on either/both ports; *_wf expected from the write-first
  // instance two cycles later, *_rf from the read-first instance one cycle later.
  task automatic xfer(input string tag,
                      input logic ae, input logic [AW-1:0] aa, input logic [31:0] aw, input logic [3:0] as,
                      input logic be, input logic [AW-1:0] ba, input logic [31:0] bw, input logic [3:0] bs,
                      input logic [31:0] a_wf, input logic [31:0] a_rf,
                      input logic [31:0] b_wf, input logic [31:0] b_rf);
    a_en = ae; a_addr = aa; a_wr = aw; a_strb = as;
    b_en = be; b_addr = ba; b_wr = bw; b_strb = bs;
    @(negedge clk);
    idle_in();
    chk({tag, ".rf_avld"}, r_avld, ae);
    chk({tag, ".rf_bvld"}, r_bvld, be);
    if (ae) chk({tag, ".rf_aread"}, r_ard, a_rf);
    if (be) chk({tag, ".rf_bread"}, r_brd, b_rf);
    chk({tag, ".wf_avld_early"}, w_avld, 1'b0);
    chk({tag, ".wf_bvld_early"}, w_bvld, 1'b0);
    @(negedge clk);
    chk({tag, ".wf_avld"}, w_avld, ae);
    chk({tag, ".wf_bvld"}, w_bvld, be);
    if (ae) chk({tag, ".wf_aread"}, w_ard, a_wf);
    if (be) chk({tag, ".wf_bread"}, w_brd, b_wf);
    chk({tag, ".rf_avld_once"}, r_avld, 1'b0);
    chk({tag, ".rf_bvld_once"}, r_bvld, 1'b0);
    @(negedge clk);
    chk({tag, ".wf_avld_once"}, w_avld, 1'b0);
    chk({tag, ".wf_bvld_once"}, w_bvld, 1'b0);
    if (ae) chk({tag, ".wf_ahold"}, w_ard, a_wf);
    if (ae) chk({tag, ".rf_ahold"}, r_ard, a_rf);
    $display("xfer %s a_en=%0b a_addr=%h b_en=%0b b_addr=%h wf_a=%h wf_b=%h rf_a=%h rf_b=%h",
             tag, ae, aa, be, ba, w_ard, w_brd, r_ard, r_brd);
  endtask

  task automatic rd(input string tag, input logic port_b, input logic [AW-1:0] ad, input logic [31:0] exp);
    if (!port_b) xfer(tag, 1'b1, ad, 32'h0, 4'h0, 1'b0, '0, 32'h0, 4'h0, exp, exp, 32'h0, 32'h0);
    else         xfer(tag, 1'b0, '0, 32'h0, 4'h0, 1'b1, ad, 32'h0, 4'h0, 32'h0, 32'h0, exp, exp);
  endtask

  // Counts busy cycles while hammering both ports with writes that must be ignored.
  task automatic wait_fill(input string tag);
    int cnt = 0;
    int bad = 0;
    while (w_busy === 1'b1 && cnt < 4 * SIZE) begin
      a_en = 1'b1; a_addr = 6'h00; a_wr = 32'hCAFEF00D; a_strb = 4'hF;
      b_en = 1'b1; b_addr = 6'h01; b_wr = 32'h12345678; b_strb = 4'hF;
      @(negedge clk);
      cnt++;
      if (w_avld || w_bvld || r_avld || r_bvld) bad++;
      if (r_busy !== w_busy) bad++;
    end
    idle_in();
    chk({tag, ".busy_cycles"}, cnt, SIZE);
    chk({tag, ".no_valid_or_mismatch"}, bad, 0);
    chk({tag, ".busy_low"}, {w_busy, r_busy}, 2'b00);
    $display("fill %s busy_cycles=%0d", tag, cnt);
  endtask

  task automatic reset_state(input string tag);
    chk({tag, ".busy"}, {w_busy, r_busy}, 2'b11);
    chk({tag, ".valids"}, {w_avld, w_bvld, r_avld, r_bvld}, 4'b0000);
    chk({tag, ".wf_aread"}, w_ard, 32'h0);
    chk({tag, ".wf_bread"}, w_brd, 32'h0);
    chk({tag, ".rf_aread"}, r_ard, 32'h0);
    chk({tag, ".rf_bread"}, r_brd, 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    idle_in();
    clr   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_state("rst0");
    rst_n = 1'b1;
    wait_fill("fill0");
    for (int a = 0; a < SIZE; a++) begin
      logic [AW-1:0] ad;
      ad = a[AW-1:0];
      rd($sformatf("zero%0d", a), ad[0], ad, 32'h0);
    end

    // Full-word write then read with latency/valid checks
    xfer("s2_wr", 1'b1, 6'h10, 32'hDEADBEEF, 4'hF, 1'b0, '0, 0, 0,
         32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    rd("s2_rd", 1'b0, 6'h10, 32'hDEADBEEF);

    // Partial strobes merge into the existing word
    xfer("s3_w1", 1'b1, 6'h11, 32'h11223344, 4'hF, 1'b0, '0, 0, 0,
         32'h11223344, 32'h0, 32'h0, 32'h0);
    xfer("s3_w2", 1'b0, '0, 0, 0, 1'b1, 6'h11, 32'hAABBCCDD, 4'h5,
         32'h0, 32'h0, 32'h11BB33DD, 32'h11223344);
    rd("s3_rd", 1'b1, 6'h11, 32'h11BB33DD);

    // Cross-port read during write: the reader sees the old word
    xfer("xrw", 1'b1, 6'h11, 32'h0, 4'h0, 1'b1, 6'h11, 32'h55667788, 4'hF,
         32'h11BB33DD, 32'h11BB33DD, 32'h55667788, 32'h11BB33DD);
    rd("xrw_rd", 1'b0, 6'h11, 32'h55667788);

    // Both ports write the same word
    xfer("s4_w1", 1'b1, 6'h20, 32'hFFFF0000, 4'hC, 1'b1, 6'h20, 32'h0000FFFF, 4'hF,
         32'hFFFF0000, 32'h0, 32'h0000FFFF, 32'h0);
    rd("s4_rd1", 1'b0, 6'h20, 32'hFFFFFFFF);
    xfer("s4_w2", 1'b1, 6'h20, 32'hFFFF0000, 4'hF, 1'b1, 6'h20, 32'h0000FFFF, 4'hF,
         32'hFFFF0000, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFFF);
    rd("s4_rd2", 1'b1, 6'h20, 32'hFFFF0000);

    // Same-port read-during-write: new word (write-first) vs old word (read-first)
    xfer("s5_w", 1'b1, 6'h30, 32'h5, 4'hF, 1'b0, '0, 0, 0, 32'h5, 32'h0, 32'h0, 32'h0);
    xfer("s5_rdw", 1'b1, 6'h30, 32'h9, 4'hF, 1'b0, '0, 0, 0, 32'h9, 32'h5, 32'h0, 32'h0);
    rd("s5_rd", 1'b0, 6'h30, 32'h9);

    // Both ports write different lanes: each sees only its own bytes merged
    xfer("xww", 1'b1, 6'h31, 32'h000000AA, 4'h1, 1'b1, 6'h31, 32'h0000BB00, 4'h2,
         32'h000000AA, 32'h0, 32'h0000BB00, 32'h0);
    rd("xww_rd", 1'b0, 6'h31, 32'h0000BBAA);

    // clr from idle: full refill, writes during busy are dropped
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr.busy_rise", {w_busy, r_busy}, 2'b11);
    wait_fill("clr");
    rd("clr_rd10", 1'b0, 6'h10, 32'h0);
    rd("clr_rd11", 1'b1, 6'h11, 32'h0);
    rd("clr_rd20", 1'b0, 6'h20, 32'h0);
    rd("clr_rd00", 1'b0, 6'h00, 32'h0);
    rd("clr_rd01", 1'b1, 6'h01, 32'h0);

    // Reset in the middle of a fill restarts it from address 0
    xfer("s6_w", 1'b1, 6'h05, 32'hABCD1234, 4'hF, 1'b0, '0, 0, 0,
         32'hABCD1234, 32'h0, 32'h0, 32'h0);
    rd("s6_rd", 1'b0, 6'h05, 32'hABCD1234);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    reset_state("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    wait_fill("rst_mid");
    rd("rst_rd05", 1'b0, 6'h05, 32'h0);
    rd("rst_rd3f", 1'b1, 6'h3F, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
